burst_ram_arbiter: RTL and testbench



---
 rtl/burst_ram_pkg.sv | 25 ++
 rtl/burst_ram_arbiter_if.sv | 25 ++
 rtl/burst_client_port.sv | 81 ++++++++
 rtl/burst_ram_arbiter.sv | 138 +++++++++++++
 tb/tb_burst_ram_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_ram_pkg.sv
// Shared types for the two-client PSRAM burst-RAM arbiter.
// Covers the command encoding, the arbiter FSM states and the queued request record.
package burst_ram_pkg;

  localparam int BURST_BEATS = 4;
  localparam int BR_ADDR_W   = 21;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } br_cmd_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BEATS = 2'd1,
    RD_WAIT  = 2'd2,
    RD_BEATS = 2'd3
  } state_t;

  typedef struct packed {
    br_cmd_t              cmd;
    logic [BR_ADDR_W-1:0] addr;
  } br_req_t;

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// Gowin burst-RAM signal bundle. A cache drives it as master; the arbiter
// takes clients on the slave modport and drives the real RAM as master.
interface burst_ram_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              cmd;
  logic              cmd_en;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wr_data;
  logic [7:0]        data_mask;
  logic [63:0]       rd_data;
  logic              rd_data_valid;

  // Commands are one-cycle strobes with no back-pressure; read beats come back
  // as a run of rd_data_valid pulses and must be accepted on the cycle they appear.
  modport master (
    output cmd, cmd_en, addr, wr_data, data_mask,
    input  rd_data, rd_data_valid
  );

  modport slave (
    input  cmd, cmd_en, addr, wr_data,
    output rd_data, rd_data_valid
  );
endinterface

// File: rtl/burst_client_port.sv
// Per-client front end: 2-entry command FIFO plus a 4-beat write buffer that
// captures write data on the strobe cycle and the three cycles after it.
module burst_client_port
  import burst_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd,
  input  logic                 cmd_en,
  input  logic [BR_ADDR_W-1:0] addr,
  input  logic [63:0]          wr_data,
  input  logic                 pop,
  input  logic                 wr_free,
  output logic                 req_valid,
  output br_req_t              req,
  output logic [63:0]          wr_beat [BURST_BEATS]
);

  br_req_t    q [2];
  logic [1:0] q_cnt;
  logic [1:0] cap_idx;
  logic       capturing;
  logic       wbuf_busy;
  br_req_t    push_req;

  assign push_req  = '{cmd: br_cmd_t'(cmd), addr: addr};
  assign req_valid = (q_cnt != 2'd0);
  assign req       = q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q[0]      <= '0;
      q[1]      <= '0;
      q_cnt     <= 2'd0;
      cap_idx   <= 2'd0;
      capturing <= 1'b0;
      wbuf_busy <= 1'b0;
      for (int i = 0; i < BURST_BEATS; i++) wr_beat[i] <= '0;
    end else begin
      assert (!(cmd_en && !pop && q_cnt == 2'd2))
        else $error("burst_client_port: command pushed into a full queue");
      assert (!(cmd_en && cmd && wbuf_busy))
        else $error("burst_client_port: write while the write buffer is still occupied");

      case ({cmd_en, pop})
        2'b10: if (q_cnt != 2'd2) begin
          q[q_cnt[0]] <= push_req;
          q_cnt       <= q_cnt + 2'd1;
        end
        2'b01: begin
          q[0]  <= q[1];
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q[0] <= push_req;
          end else begin
            q[0] <= q[1];
            q[1] <= push_req;
          end
        end
        default: ;
      endcase

      // Beat 0 is in the buffer by the earliest issue cycle, and beat k one
      // cycle ahead of its read-out, so no bypass from wr_data is needed.
      if (wr_free) wbuf_busy <= 1'b0;
      if (cmd_en && cmd) begin
        wr_beat[0] <= wr_data;
        cap_idx    <= 2'd1;
        capturing  <= 1'b1;
        wbuf_busy  <= 1'b1;
      end else if (capturing) begin
        wr_beat[cap_idx] <= wr_data;
        cap_idx          <= cap_idx + 2'd1;
        if (cap_idx == 2'd3) capturing <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one PSRAM burst port between the I-cache (client 0) and D-cache (client 1):
// round-robin issue, command-interval pacing, write replay and read-beat steering.
module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH     = 21,
  parameter int COMMAND_DELAY_INTERVAL = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  burst_ram_arbiter_if.slave  c0,
  burst_ram_arbiter_if.slave  c1,
  burst_ram_arbiter_if.master br,
  output state_t              dbg_state
);

  localparam int DLY_W = $clog2(COMMAND_DELAY_INTERVAL + 1);

  if (RAM_DEPTH_BITWIDTH != BR_ADDR_W || BURST_BEATS != 4) begin : g_bad_cfg
    $error("burst_ram_arbiter: only 21-bit addresses and 4-beat bursts are supported");
  end

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic             last_grant;
  logic             owner;
  logic [1:0]       beat_cnt;

  logic             rv0, rv1;
  br_req_t          req0, req1, req_w;
  logic [63:0]      beats0 [BURST_BEATS];
  logic [63:0]      beats1 [BURST_BEATS];
  logic             issue, win, steer;

  burst_client_port u_port0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (c0.cmd),
    .cmd_en    (c0.cmd_en),
    .addr      (c0.addr),
    .wr_data   (c0.wr_data),
    .pop       (issue && !win),
    .wr_free   (state == WR_BEATS && beat_cnt == 2'd3 && !owner),
    .req_valid (rv0),
    .req       (req0),
    .wr_beat   (beats0)
  );

  burst_client_port u_port1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (c1.cmd),
    .cmd_en    (c1.cmd_en),
    .addr      (c1.addr),
    .wr_data   (c1.wr_data),
    .pop       (issue && win),
    .wr_free   (state == WR_BEATS && beat_cnt == 2'd3 && owner),
    .req_valid (rv1),
    .req       (req1),
    .wr_beat   (beats1)
  );

  // Issue is decoded from registered queue/FSM state only, so a strobe at t
  // reaches the RAM at t+1 without any input-to-output path.
  always_comb begin
    issue = (state == IDLE) && (dly_cnt == '0) && (rv0 || rv1);
    win   = (rv0 && rv1) ? ~last_grant : ~rv0;
    req_w = win ? req1 : req0;
  end

  assign steer     = (state == RD_WAIT || state == RD_BEATS) && br.rd_data_valid;
  assign dbg_state = state;
  assign br.data_mask = 8'h00;

  always_comb begin
    br.cmd_en  = issue;
    br.cmd     = 1'b0;
    br.addr    = '0;
    br.wr_data = '0;
    if (issue) begin
      br.cmd  = req_w.cmd;
      br.addr = req_w.addr;
      if (req_w.cmd == WRITE) br.wr_data = win ? beats1[0] : beats0[0];
    end else if (state == WR_BEATS) begin
      br.wr_data = owner ? beats1[beat_cnt] : beats0[beat_cnt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      dly_cnt          <= '0;
      last_grant       <= 1'b1;
      owner            <= 1'b0;
      beat_cnt         <= 2'd0;
      c0.rd_data       <= '0;
      c0.rd_data_valid <= 1'b0;
      c1.rd_data       <= '0;
      c1.rd_data_valid <= 1'b0;
    end else begin
      if (issue)                dly_cnt <= DLY_W'(COMMAND_DELAY_INTERVAL);
      else if (dly_cnt != '0)   dly_cnt <= dly_cnt - DLY_W'(1);

      c0.rd_data_valid <= steer && !owner;
      c0.rd_data       <= (steer && !owner) ? br.rd_data : '0;
      c1.rd_data_valid <= steer && owner;
      c1.rd_data       <= (steer && owner) ? br.rd_data : '0;

      case (state)
        IDLE: if (issue) begin
          last_grant <= win;
          owner      <= win;
          if (req_w.cmd == WRITE) begin
            state    <= WR_BEATS;
            beat_cnt <= 2'd1;
          end else begin
            state    <= RD_WAIT;
            beat_cnt <= 2'd0;
          end
        end
        WR_BEATS: begin
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state <= IDLE;
        end
        RD_WAIT: if (br.rd_data_valid) begin
          beat_cnt <= 2'd1;
          state    <= RD_BEATS;
        end
        RD_BEATS: if (br.rd_data_valid) begin
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter: a table of single-client transactions
// plus hand-written contention, starvation and mid-burst reset sequences.
module tb_burst_ram_arbiter;
  import burst_ram_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc = 0;
  state_t dbg_state;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  burst_ram_arbiter_if #(.ADDR_W(21)) c0_if ();
  burst_ram_arbiter_if #(.ADDR_W(21)) c1_if ();
  burst_ram_arbiter_if #(.ADDR_W(21)) br_if ();

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH     (21),
    .COMMAND_DELAY_INTERVAL (13)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .c0        (c0_if),
    .c1        (c1_if),
    .br        (br_if),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct { int cyc; logic cmd; logic [20:0] addr; } cmd_rec_t;
  typedef struct { logic [20:0] addr; logic [255:0] d; }     wr_rec_t;
  typedef struct { int cyc; logic [63:0] d; }               rx_rec_t;
  typedef struct { int start; logic [20:0] addr; }          ram_req_t;

  cmd_rec_t    cmd_log [$];
  wr_rec_t     wr_log [$];
  rx_rec_t     rx0 [$];
  rx_rec_t     rx1 [$];
  ram_req_t    ram_q [$];
  logic [63:0] exp_q [$];

  int n_vec = 0;
  int n_bad = 0;
  int strobe_cyc [2];
  int strobed [2];
  int issued [2];

  function automatic logic [63:0] ram_word(input logic [20:0] a, input int k);
    return {11'h0, a, 16'hCAFE, 16'(k)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_logs();
    cmd_log.delete(); wr_log.delete(); rx0.delete(); rx1.delete(); exp_q.delete();
  endtask

  // ---------------- RAM model and monitors ----------------
  logic        ram_busy = 1'b0;
  int          ram_beat = 0;
  logic [20:0] ram_addr = '0;
  int          wcap_left = 0;
  int          wcap_idx = 0;
  logic [20:0] wcap_addr = '0;
  logic [255:0] wcap_data = '0;

  initial begin
    br_if.rd_data = '0;
    br_if.rd_data_valid = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ram_q.delete();
      ram_busy = 1'b0;
      wcap_left = 0;
      br_if.rd_data_valid = 1'b0;
      br_if.rd_data = '0;
    end else begin
      if (c0_if.rd_data_valid) rx0.push_back('{cyc, c0_if.rd_data});
      if (c1_if.rd_data_valid) rx1.push_back('{cyc, c1_if.rd_data});

      br_if.rd_data_valid = 1'b0;
      br_if.rd_data = '0;
      if (!ram_busy && ram_q.size() > 0 && ram_q[0].start <= cyc) begin
        ram_busy = 1'b1;
        ram_addr = ram_q[0].addr;
        ram_beat = 0;
        void'(ram_q.pop_front());
      end
      if (ram_busy) begin
        br_if.rd_data_valid = 1'b1;
        br_if.rd_data = ram_word(ram_addr, ram_beat);
        ram_beat++;
        if (ram_beat == 4) ram_busy = 1'b0;
      end

      if (br_if.cmd_en) begin
        cmd_log.push_back('{cyc, br_if.cmd, br_if.addr});
        issued[br_if.addr[20] ? 1 : 0]++;
        if (br_if.cmd == 1'b0) begin
          ram_q.push_back('{cyc + 3, br_if.addr});
        end else begin
          wcap_addr = br_if.addr;
          wcap_data = '0;
          wcap_data[63:0] = br_if.wr_data;
          wcap_idx = 1;
          wcap_left = 3;
        end
      end else if (wcap_left > 0) begin
        wcap_data[64*wcap_idx +: 64] = br_if.wr_data;
        wcap_idx++;
        wcap_left--;
        if (wcap_left == 0) wr_log.push_back('{wcap_addr, wcap_data});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_cl(input int c, input logic en, input logic cmd,
                        input logic [20:0] addr, input logic [63:0] d);
    if (c == 0) begin
      c0_if.cmd_en = en; c0_if.cmd = cmd; c0_if.addr = addr; c0_if.wr_data = d;
    end else begin
      c1_if.cmd_en = en; c1_if.cmd = cmd; c1_if.addr = addr; c1_if.wr_data = d;
    end
  endtask

  task automatic drive_cmd(input int c, input logic cmd, input logic [20:0] addr,
                           input logic [255:0] wd);
    @(negedge clk);
    strobe_cyc[c] = cyc;
    set_cl(c, 1'b1, cmd, addr, wd[63:0]);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      set_cl(c, 1'b0, 1'b0, '0, wd[64*k +: 64]);
    end
    @(negedge clk);
    set_cl(c, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic hammer(input int c);
    for (int i = 0; i < 10; i++) begin
      int guard;
      guard = 0;
      while ((strobed[c] - issued[c]) >= 2 && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      drive_cmd(c, 1'b0, (c == 1) ? (21'h100000 | 21'(i)) : 21'(i * 16), '0);
      strobed[c]++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Waits for n logged commands; reports a timeout as a failed comparison.
  task automatic wait_cmds(input string name, input int n, input int budget);
    for (int i = 0; i < budget && cmd_log.size() < n; i++) @(negedge clk);
    check({name, "_cmd_timeout"}, 64'(cmd_log.size() >= n), 64'd1);
  endtask

  task automatic wait_rx(input string name, input int c, input int n, input int budget);
    for (int i = 0; i < budget && ((c == 0) ? rx0.size() : rx1.size()) < n; i++) @(negedge clk);
    check({name, "_rx_timeout"}, 64'(((c == 0) ? rx0.size() : rx1.size()) >= n), 64'd1);
  endtask

  // Checks four beats of client c against exp_q, consecutive and starting at first_cyc.
  task automatic check_rx(input string name, input int c, input int first_cyc);
    rx_rec_t r;
    if (((c == 0) ? rx0.size() : rx1.size()) >= 4) begin
      for (int k = 0; k < 4; k++) begin
        r = (c == 0) ? rx0[k] : rx1[k];
        check($sformatf("%s_data%0d", name, k), r.d, exp_q.pop_front());
        check($sformatf("%s_cyc%0d", name, k), 64'(r.cyc), 64'(first_cyc + k));
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           client;
    logic         cmd;
    logic [20:0]  addr;
    logic [255:0] wdata;
    logic         exp_cmd;
    logic [20:0]  exp_addr;
    int           exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    c0_if.cmd = 1'b0; c0_if.cmd_en = 1'b0; c0_if.addr = '0; c0_if.wr_data = '0; c0_if.data_mask = '0;
    c1_if.cmd = 1'b0; c1_if.cmd_en = 1'b0; c1_if.addr = '0; c1_if.wr_data = '0; c1_if.data_mask = '0;
    strobed[0] = 0; strobed[1] = 0; issued[0] = 0; issued[1] = 0;

    vecs[0] = '{0, 1'b0, 21'h000100, 256'h0, 1'b0, 21'h000100, 1};
    vecs[1] = '{1, 1'b1, 21'h000040,
                {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                1'b1, 21'h000040, 1};
    vecs[2] = '{1, 1'b0, 21'h000040, 256'h0, 1'b0, 21'h000040, 1};
    vecs[3] = '{0, 1'b1, 21'h1FFFFF,
                {64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000,
                 64'h8000_0000_0000_0001, 64'h0000_0000_0000_0000},
                1'b1, 21'h1FFFFF, 1};
    vecs[4] = '{0, 1'b0, 21'h000000, 256'h0, 1'b0, 21'h000000, 1};
    vecs[5] = '{1, 1'b0, 21'h1FFFFF, 256'h0, 1'b0, 21'h1FFFFF, 1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_br_cmd_en",  64'(br_if.cmd_en), 64'd0);
    check("rst_br_cmd",     64'(br_if.cmd), 64'd0);
    check("rst_br_addr",    64'(br_if.addr), 64'd0);
    check("rst_br_wr_data", br_if.wr_data, 64'd0);
    check("rst_br_mask",    64'(br_if.data_mask), 64'd0);
    check("rst_c0_valid",   64'(c0_if.rd_data_valid), 64'd0);
    check("rst_c1_valid",   64'(c1_if.rd_data_valid), 64'd0);
    check("rst_c0_data",    c0_if.rd_data, 64'd0);
    check("rst_state",      64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single uncontended transactions.
    for (int v = 0; v < 6; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      reset_logs();
      drive_cmd(vecs[v].client, vecs[v].cmd, vecs[v].addr, vecs[v].wdata);
      wait_cmds(nm, 1, 10);
      if (cmd_log.size() >= 1) begin
        check({nm, "_lat"},  64'(cmd_log[0].cyc - strobe_cyc[vecs[v].client]), 64'(vecs[v].exp_lat));
        check({nm, "_cmd"},  64'(cmd_log[0].cmd), 64'(vecs[v].exp_cmd));
        check({nm, "_addr"}, 64'(cmd_log[0].addr), 64'(vecs[v].exp_addr));
        if (vecs[v].cmd) begin
          for (int i = 0; i < 10 && wr_log.size() < 1; i++) @(negedge clk);
          check({nm, "_wr_timeout"}, 64'(wr_log.size()), 64'd1);
          if (wr_log.size() >= 1)
            for (int k = 0; k < 4; k++)
              check($sformatf("%s_wbeat%0d", nm, k), wr_log[0].d[64*k +: 64], vecs[v].wdata[64*k +: 64]);
        end else begin
          for (int k = 0; k < 4; k++) exp_q.push_back(ram_word(vecs[v].addr, k));
          wait_rx(nm, vecs[v].client, 4, 30);
          check_rx(nm, vecs[v].client, cmd_log[0].cyc + 4);
          repeat (3) @(negedge clk);
          check({nm, "_other_valid"}, 64'((vecs[v].client == 0) ? rx1.size() : rx0.size()), 64'd0);
        end
      end
      repeat (20) @(negedge clk);
    end

    // Simultaneous reads after reset: client 0 wins the first tie.
    do_reset();
    reset_logs();
    fork
      drive_cmd(0, 1'b0, 21'h000200, '0);
      drive_cmd(1, 1'b0, 21'h000300, '0);
    join
    wait_cmds("simul", 2, 60);
    if (cmd_log.size() >= 2) begin
      check("simul_first_addr",  64'(cmd_log[0].addr), 64'h200);
      check("simul_second_addr", 64'(cmd_log[1].addr), 64'h300);
      check("simul_gap",         64'(cmd_log[1].cyc - cmd_log[0].cyc), 64'd14);
      for (int k = 0; k < 4; k++) exp_q.push_back(ram_word(21'h200, k));
      wait_rx("simul_c0", 0, 4, 30);
      check_rx("simul_c0", 0, cmd_log[0].cyc + 4);
      if (rx0.size() >= 4)
        check("simul_after_beat4", 64'(rx0[3].cyc < cmd_log[1].cyc), 64'd1);
      for (int k = 0; k < 4; k++) exp_q.push_back(ram_word(21'h300, k));
      wait_rx("simul_c1", 1, 4, 30);
      check_rx("simul_c1", 1, cmd_log[1].cyc + 4);
    end
    repeat (20) @(negedge clk);

    // Evict then refill: c0's write waits behind c1's read and replays from the buffer.
    reset_logs();
    fork
      drive_cmd(1, 1'b0, 21'h000080, '0);
      begin
        @(negedge clk);
        drive_cmd(0, 1'b1, 21'h000120,
                  {64'h3333_0000_0000_3333, 64'h2222_0000_0000_2222,
                   64'h1111_0000_0000_1111, 64'h0000_5555_5555_0000});
      end
    join
    repeat (8) @(negedge clk);
    drive_cmd(0, 1'b0, 21'h000120, '0);
    wait_cmds("evict", 3, 80);
    if (cmd_log.size() >= 3) begin
      check("evict_order0", {42'h0, cmd_log[0].cmd, cmd_log[0].addr}, {42'h0, 1'b0, 21'h080});
      check("evict_order1", {42'h0, cmd_log[1].cmd, cmd_log[1].addr}, {42'h0, 1'b1, 21'h120});
      check("evict_order2", {42'h0, cmd_log[2].cmd, cmd_log[2].addr}, {42'h0, 1'b0, 21'h120});
      check("evict_gap_wr", 64'(cmd_log[1].cyc - cmd_log[0].cyc), 64'd14);
      check("evict_gap_rd", 64'(cmd_log[2].cyc - cmd_log[1].cyc), 64'd14);
      check("evict_wr_count", 64'(wr_log.size()), 64'd1);
      if (wr_log.size() >= 1) begin
        check("evict_wbeat0", wr_log[0].d[63:0],    64'h0000_5555_5555_0000);
        check("evict_wbeat1", wr_log[0].d[127:64],  64'h1111_0000_0000_1111);
        check("evict_wbeat2", wr_log[0].d[191:128], 64'h2222_0000_0000_2222);
        check("evict_wbeat3", wr_log[0].d[255:192], 64'h3333_0000_0000_3333);
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(ram_word(21'h120, k));
      wait_rx("evict_c0", 0, 4, 30);
      check_rx("evict_c0", 0, cmd_log[2].cyc + 4);
    end
    repeat (20) @(negedge clk);

    // Starvation: both clients keep their queues topped up; grants must alternate.
    reset_logs();
    strobed[0] = 0; strobed[1] = 0; issued[0] = 0; issued[1] = 0;
    fork
      hammer(0);
      hammer(1);
    join
    wait_cmds("starve", 20, 600);
    if (cmd_log.size() >= 20)
      for (int i = 1; i < 20; i++)
        check($sformatf("starve_alt%0d", i), 64'(cmd_log[i].addr[20] != cmd_log[i-1].addr[20]), 64'd1);
    repeat (40) @(negedge clk);

    // Reset during RD_BEATS clears outputs immediately; a new read then works.
    reset_logs();
    drive_cmd(0, 1'b0, 21'h0003A0, '0);
    for (int i = 0; i < 30 && dbg_state != RD_BEATS; i++) @(negedge clk);
    check("midrst_reached_rd_beats", 64'(dbg_state), 64'(RD_BEATS));
    rst_n = 1'b0;
    #1;
    check("midrst_c0_valid", 64'(c0_if.rd_data_valid), 64'd0);
    check("midrst_c0_data",  c0_if.rd_data, 64'd0);
    check("midrst_cmd_en",   64'(br_if.cmd_en), 64'd0);
    check("midrst_state",    64'(dbg_state), 64'(IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    reset_logs();
    drive_cmd(1, 1'b0, 21'h0000AA, '0);
    wait_cmds("postrst", 1, 10);
    if (cmd_log.size() >= 1) begin
      check("postrst_lat",  64'(cmd_log[0].cyc - strobe_cyc[1]), 64'd1);
      check("postrst_addr", 64'(cmd_log[0].addr), 64'h0AA);
      for (int k = 0; k < 4; k++) exp_q.push_back(ram_word(21'h0AA, k));
      wait_rx("postrst", 1, 4, 30);
      check_rx("postrst", 1, cmd_log[0].cyc + 4);
      check("postrst_c0_quiet", 64'(rx0.size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
